// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states,
// header field positions and memory byte strides.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    LD_I   = 3'd2,
    LD_DLO = 3'd3,
    LD_DHI = 3'd4,
    RUN    = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam int N_LSB       = 0;
  localparam int N_MSB       = 15;
  localparam int M_LSB       = 16;
  localparam int M_MSB       = 31;
  localparam int IMEM_STRIDE = 4;
  localparam int DMEM_STRIDE = 8;

  function automatic logic [15:0] hdr_n(input logic [31:0] hdr);
    return hdr[N_MSB:N_LSB];
  endfunction

  function automatic logic [15:0] hdr_m(input logic [31:0] hdr);
    return hdr[M_MSB:M_LSB];
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready word stream feeding the program loader.
interface program_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader_write_port.sv
// One external memory write port: registered address/data/strobe plus the
// running word index that forms the byte address.
module loader_write_port #(
  parameter int DATA_W = 32,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [63:0]       addr,
  output logic              wen,
  output logic [DATA_W-1:0] data,
  output logic [15:0]       idx
);

  localparam int SHIFT = $clog2(STRIDE);

  logic [63:0]       addr_r;
  logic              wen_r;
  logic [DATA_W-1:0] data_r;
  logic [15:0]       idx_r;

  // Strobe is a single-cycle pulse; address and data hold between writes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_r <= 64'd0;
      wen_r  <= 1'b0;
      data_r <= '0;
      idx_r  <= 16'd0;
    end else begin
      wen_r <= 1'b0;
      if (clr) begin
        idx_r  <= 16'd0;
        addr_r <= 64'd0;
      end else if (wr) begin
        wen_r  <= 1'b1;
        data_r <= wdata;
        addr_r <= {48'd0, idx_r} << SHIFT;
        idx_r  <= idx_r + 16'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  assign addr = addr_r;
  assign wen  = wen_r;
  assign data = data_r;
  assign idx  = idx_r;

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams a header + IMEM words + DMEM doublewords into the
// core's external memory ports, then enables the core.
module program_loader
  import cpu_pkg::*;
#(
  parameter int IMEM_MAX_WORDS  = 128,
  parameter int DMEM_MAX_DWORDS = 128
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    start,
  program_loader_if.slave         stream,
  output logic [63:0]             addr_ext,
  output logic                    wen_ext,
  output logic                    ren_ext,
  output logic [31:0]             wdata_ext,
  output logic [63:0]             addr_ext_2,
  output logic                    wen_ext_2,
  output logic                    ren_ext_2,
  output logic [63:0]             wdata_ext_2,
  output logic                    cpu_enable,
  output logic                    load_done,
  output logic                    load_error
);

  state_t      state_r, next_state_s;
  logic [15:0] n_r, m_r;
  logic [31:0] lo_r;
  logic        cpu_enable_r, load_done_r, load_error_r;

  logic        in_ready_s, hs_s, hdr_hs_s, imem_wr_s, dmem_wr_s;
  logic [15:0] hdr_n_s, hdr_m_s, imem_idx_s, dmem_idx_s;
  logic        imem_last_s, dmem_last_s, hdr_bad_s;

  assign hs_s        = stream.in_valid & in_ready_s;
  assign hdr_n_s     = hdr_n(stream.in_data);
  assign hdr_m_s     = hdr_m(stream.in_data);
  assign hdr_bad_s   = (hdr_n_s > 16'(IMEM_MAX_WORDS)) || (hdr_m_s > 16'(DMEM_MAX_DWORDS));
  assign imem_last_s = (imem_idx_s + 16'd1) == n_r;
  assign dmem_last_s = (dmem_idx_s + 16'd1) == m_r;

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start is only honoured outside the loading states.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = HDR;
        else       next_state_s = state_r;
      end
      HDR: begin
        if (!hs_s)               next_state_s = state_r;
        else if (hdr_bad_s)      next_state_s = ERROR;
        else if (hdr_n_s != 16'd0) next_state_s = LD_I;
        else if (hdr_m_s != 16'd0) next_state_s = LD_DLO;
        else                     next_state_s = RUN;
      end
      LD_I: begin
        if (hs_s && imem_last_s) next_state_s = (m_r != 16'd0) ? LD_DLO : RUN;
        else                     next_state_s = state_r;
      end
      LD_DLO: begin
        if (hs_s) next_state_s = LD_DHI;
        else      next_state_s = state_r;
      end
      LD_DHI: begin
        if (hs_s) next_state_s = dmem_last_s ? RUN : LD_DLO;
        else      next_state_s = state_r;
      end
      RUN, ERROR: begin
        if (start) next_state_s = HDR;
        else       next_state_s = state_r;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: ready depends on state alone, never on in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    hdr_hs_s   = 1'b0;
    imem_wr_s  = 1'b0;
    dmem_wr_s  = 1'b0;
    case (state_r)
      HDR: begin
        in_ready_s = 1'b1;
        hdr_hs_s   = stream.in_valid;
      end
      LD_I: begin
        in_ready_s = 1'b1;
        imem_wr_s  = stream.in_valid;
      end
      LD_DLO: in_ready_s = 1'b1;
      LD_DHI: begin
        in_ready_s = 1'b1;
        dmem_wr_s  = stream.in_valid;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // Header fields and the low half of the doubleword under assembly.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      n_r  <= 16'd0;
      m_r  <= 16'd0;
      lo_r <= 32'd0;
    end else begin
      if (hdr_hs_s) begin
        n_r <= hdr_n_s;
        m_r <= hdr_m_s;
      end else begin
        n_r <= n_r;
        m_r <= m_r;
      end
      if (hs_s && state_r == LD_DLO) lo_r <= stream.in_data;
      else                           lo_r <= lo_r;
    end
  end

  // Enable waits one cycle past a final strobe so it never overlaps a write.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cpu_enable_r <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      cpu_enable_r <= (next_state_s == RUN) && !(imem_wr_s || dmem_wr_s);
      load_done_r  <= (next_state_s == RUN);
      load_error_r <= (next_state_s == ERROR);
    end
  end

  loader_write_port #(.DATA_W(32), .STRIDE(IMEM_STRIDE)) u_imem_port (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (hdr_hs_s),
    .wr    (imem_wr_s),
    .wdata (stream.in_data),
    .addr  (addr_ext),
    .wen   (wen_ext),
    .data  (wdata_ext),
    .idx   (imem_idx_s)
  );

  loader_write_port #(.DATA_W(64), .STRIDE(DMEM_STRIDE)) u_dmem_port (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (hdr_hs_s),
    .wr    (dmem_wr_s),
    .wdata ({stream.in_data, lo_r}),
    .addr  (addr_ext_2),
    .wen   (wen_ext_2),
    .data  (wdata_ext_2),
    .idx   (dmem_idx_s)
  );

  assign stream.in_ready = in_ready_s;
  assign ren_ext         = 1'b0;
  assign ren_ext_2       = 1'b0;
  assign cpu_enable      = cpu_enable_r;
  assign load_done       = load_done_r;
  assign load_error      = load_error_r;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader directly upstream of the pipelined RISC-V core.
- Accepts a 32-bit valid/ready word stream and writes instruction memory through the core's external port (addr_ext/wen_ext/wdata_ext).
- Then writes data memory through the second external port (addr_ext_2/wen_ext_2/wdata_ext_2), assembling 64-bit doublewords.
- Finally raises the core's enable. It holds the core disabled during any load and flags malformed images.

Parameters:
- IMEM_MAX_WORDS, 128, capacity of instruction memory in 32-bit words (512 bytes).
- DMEM_MAX_DWORDS, 128, capacity of data memory in 64-bit doublewords (1024 bytes).

Ports:
- clk  input  1  main clock
- arst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a new load from IDLE, RUN or ERROR
- in_valid  input  1  stream word valid
- in_data  input  32  stream word
- in_ready  output  1  loader accepts in_data this cycle when in_valid is also high
- addr_ext  output  64  instruction memory byte address
- wen_ext  output  1  instruction memory write strobe
- ren_ext  output  1  constant 0
- wdata_ext  output  32  instruction word
- addr_ext_2  output  64  data memory byte address
- wen_ext_2  output  1  data memory write strobe
- ren_ext_2  output  1  constant 0
- wdata_ext_2  output  64  data doubleword
- cpu_enable  output  1  drives the core enable
- load_done  output  1  high while in RUN
- load_error  output  1  high while in ERROR

Behaviour:
- Clocking and reset: one clock, clk. Reset arst_n is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0, including addresses, data, in_ready and cpu_enable.
- Reset mid-load aborts immediately. Any partially written image is left in memory, and no further strobes are issued.
- Image format:
  - Word 0 is the header: N = in_data[15:0] (IMEM word count), M = in_data[31:16] (DMEM doubleword count).
  - Then N instruction words.
  - Then M doublewords, each sent as two stream words, low half first.
- A handshake occurs on a cycle where in_valid and in_ready are both high. in_data is ignored when there is no handshake.
- in_ready is high only in HDR, LD_I, LD_DLO and LD_DHI. It is combinational from state only, never from in_valid.
- States and transitions:
  - IDLE: start -> HDR.
  - HDR: on handshake, if N > IMEM_MAX_WORDS or M > DMEM_MAX_DWORDS -> ERROR. Otherwise -> LD_I if N != 0; else LD_DLO if M != 0; else RUN. Counters and addresses are cleared to 0 on this handshake.
  - LD_I: each handshake registers wdata_ext <= in_data, addr_ext <= 4*i and pulses wen_ext for exactly one cycle (the cycle after the handshake). After word N-1 -> LD_DLO if M != 0, else RUN.
  - LD_DLO: handshake latches the low 32 bits -> LD_DHI.
  - LD_DHI: handshake registers wdata_ext_2 <= {in_data, low}, addr_ext_2 <= 8*j and pulses wen_ext_2 for one cycle. After doubleword M-1 -> RUN, else -> LD_DLO.
  - RUN: cpu_enable = 1, load_done = 1. start -> HDR, with cpu_enable dropping on the same edge.
  - ERROR: load_error = 1, cpu_enable = 0. start -> HDR.
- Write latency: exactly 1 cycle from handshake to strobe. Back-to-back handshakes give back-to-back strobes, so full throughput is 1 word/cycle.
- Address and data outputs hold their last values between strobes.
- cpu_enable is registered. It first rises on the cycle after the final wen_ext or wen_ext_2 pulse, never on the same cycle as a strobe. For an empty image (N = M = 0) it rises the cycle after the header handshake.
- start is ignored in HDR, LD_I, LD_DLO and LD_DHI.
- in_valid low mid-load stalls the loader. State and counters hold, and no strobes are issued.
- Counters are 16-bit. Addresses are formed as zero-extended index << 2 or << 3 into 64 bits.
- wen_ext and wen_ext_2 are never high in the same cycle.

Decomposition:
- Shared package (cpu_pkg):
  - state enumeration: IDLE, HDR, LD_I, LD_DLO, LD_DHI, RUN, ERROR
  - header field constants: N_LSB=0, N_MSB=15, M_LSB=16, M_MSB=31
  - byte strides: IMEM_STRIDE=4, DMEM_STRIDE=8
- One natural sub-module: loader_write_port. It is parameterised on data width and stride, and holds the registered address, data and strobe plus the index counter. It is instantiated twice, once for IMEM and once for DMEM.
- The FSM remains in program_loader.

Test Plan:
- Reset with in_valid=1 -> in_ready=0, cpu_enable=0, all strobes 0. After start, in_ready=1 the next cycle.
- Basic image: start, header 0x0001_0002, words 0x00500093, 0x00A00113, 0xDEADBEEF, 0x01234567 with continuous valid:
  - wen_ext pulses at addr 0 then 4 with matching data;
  - then one wen_ext_2 at addr 0 with data 0x01234567_DEADBEEF;
  - cpu_enable rises one cycle after that pulse.
- Stall: same image with in_valid toggled 1/0 every cycle -> identical writes, one strobe per handshake, no strobe on stalled cycles.
- Bounds check:
  - header 0x0000_0081 (N=129) -> ERROR, load_error=1, no strobes.
  - header 0x0080_0080 (N=128, M=128) is accepted, and the last IMEM write goes to addr 508.
- Empty image: header 0x0000_0000 -> RUN, with cpu_enable rising the cycle after the header handshake.
- Reload and reset:
  - start during RUN -> cpu_enable drops on the next edge and the new image loads.
  - arst_n asserted mid LD_DHI -> outputs 0 asynchronously and state IDLE; start afterwards loads normally.
